alu_op_issue: RTL and testbench
===============================

// Module: alu_op_issue
// PURPOSE
//  ID->EX issue stage for the 5-stage MIPS pipeline. Decodes opcode/funct into the 3-bit ALU op and selects operand B.
//  Registers {A, B, ALU op} for the EX-stage ALU, the consumer of this encoding.
//  Valid/ready on both sides, a 2-entry skid buffer and a flush for branch/jump squash.
// PARAMETERS
//  DW      32  operand width
//  RW      5   register-index width (forwarding compare)
// PORTS
//  clk          in   1    rising-edge clock
//  rst_n        in   1    asynchronous active-low reset
//  in_valid     in   1    decoded instruction + operands present
//  in_ready     out  1    stage can accept this cycle
//  opcode       in   6    instr[31:26]
//  funct        in   6    instr[5:0]
//  rs_data      in   DW   register-file read port 1
//  rt_data      in   DW   register-file read port 2
//  imm_sext     in   DW   sign-extended immediate
//  flush        in   1    squash all buffered entries
//  out_valid    out  1    ALU operands valid
//  out_ready    in   1    EX stage accepts (low = stall)
//  alu_a        out  DW   signed operand A
//  alu_b        out  DW   signed operand B
//  alu_op       out  3    000 add, 001 sub, 010 and, 011 or, 100 slt, 111 hold
//  illegal      out  1    entry at output had an undecodable opcode/funct
// BEHAVIOUR
//  Reset (async, rst_n=0): both entries invalid; out_valid=0, in_ready=1, alu_a=alu_b=0, alu_op=3'b111, illegal=0.
//  Decode (combinational at input, registered on accept):
//   opcode 000000 + funct 100000/100010/100100/100101/101010 -> 000/001/010/011/100, B=rt_data.
//   addi 001000, lw 100011, sw 101011 -> 000, B=imm_sext. slti 001010 -> 100, B=imm_sext.
//   beq 000100 -> 001, B=rt_data. j 000010 -> 111, B=0. Anything else -> 111, B=0, illegal=1.
//  A = rs_data in every case. All arithmetic is left to the ALU; this stage does no width change.
//  Buffer FSM, states EMPTY / ONE / TWO (main reg drives outputs, skid reg behind it):
//   EMPTY: accept -> ONE.
//   ONE: accept & !pop -> TWO (new entry into skid); pop & !accept -> EMPTY; accept & pop -> ONE (new entry to main).
//   TWO: pop -> ONE (skid moves to main); no accept possible.
//  accept = in_valid & in_ready. pop = out_valid & out_ready. in_ready = (state != TWO).
//  This is a registered ready; 1-cycle latency input->output when not stalled; full throughput.
//  Outputs are stable while out_valid=1 and out_ready=0.
//  When out_valid=0: alu_op=3'b111 so the ALU holds its last result; alu_a/alu_b keep their last values.
//  flush: next edge -> EMPTY; any same-cycle accept is dropped; a same-cycle pop still completes.
//  Reset mid-stall clears everything; no partial entry survives.
// CONFIGURATION
//  ALU_FWD_EN defined: extra inputs exmem_wr, exmem_rd[RW], exmem_res[DW], memwb_wr, memwb_rd[RW], memwb_res[DW],
//   plus rs_idx/rt_idx[RW] carried with each entry.
//   Forwarding is applied to main-register operands every cycle while the entry is held.
//   EX/MEM has priority over MEM/WB; $0 is never forwarded; B is forwarded only when B came from rt.
//  ALU_FWD_EN undefined: none of these ports exist; operands pass through unchanged.
// STRUCTURE
//  Shared package mips_pkg: alu_op_t enum (ADD, SUB, AND, OR, SLT, HOLD), opcode/funct localparams,
//   issue_entry_t struct {a, b, op, illegal, b_is_rt, rs_idx, rt_idx}.
//  One sub-module, alu_op_decode: combinational opcode/funct -> {op, b_sel, illegal}.
//  The FSM and skid registers stay in alu_op_issue.
// TESTING
//  1. Reset, then in_valid add (rs=5, rt=7), out_ready=1 -> next cycle out_valid=1, alu_op=000, A=5, B=7.
//  2. out_ready=0, issue addi imm=-4 then sub -> after 2 accepts in_ready=0; release -> addi (000, B=-4) then sub (001).
//  3. Skid full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, alu_op=111.
//  4. opcode 111111 -> alu_op=111, illegal=1, B=0; slti imm=3 -> alu_op=100, B=3.
//  5. Assert rst_n=0 asynchronously while in TWO -> out_valid=0 immediately; no stale entry after release.
//  6. ALU_FWD_EN: exmem_wr=1, exmem_rd=rs_idx=8, exmem_res=99 -> alu_a=99; with rd=0 -> A=rs_data.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: ALU op encoding, opcode/funct values, issue-buffer entry.
// Pure declarations: no latency, no flow control.
package mips_pkg;

  localparam int XLEN = 32;
  localparam int RIDX = 5;

  typedef enum logic [2:0] {
    ADD  = 3'b000,
    SUB  = 3'b001,
    AND  = 3'b010,
    OR   = 3'b011,
    SLT  = 3'b100,
    HOLD = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    B_RT   = 2'd0,
    B_IMM  = 2'd1,
    B_ZERO = 2'd2
  } b_sel_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_t;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_J     = 6'b000010;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_SLTI  = 6'b001010;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    alu_op_t         op;
    logic            illegal;
    logic            b_is_rt;
    logic [RIDX-1:0] rs_idx;
    logic [RIDX-1:0] rt_idx;
  } issue_entry_t;

endpackage

// File: rtl/alu_op_decode.sv
// Opcode/funct -> {ALU op, operand-B source, illegal}; purely combinational.
// Zero latency; no flow control.
module alu_op_decode
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output alu_op_t    op,
  output b_sel_t     b_sel,
  output logic       illegal
);

  always_comb begin
    op      = HOLD;
    b_sel   = B_ZERO;
    illegal = 1'b0;
    case (opcode)
      OPC_RTYPE: begin
        b_sel = B_RT;
        case (funct)
          FN_ADD:  op = ADD;
          FN_SUB:  op = SUB;
          FN_AND:  op = AND;
          FN_OR:   op = OR;
          FN_SLT:  op = SLT;
          default: begin
            b_sel   = B_ZERO;
            illegal = 1'b1;
          end
        endcase
      end
      OPC_ADDI, OPC_LW, OPC_SW: begin
        op    = ADD;
        b_sel = B_IMM;
      end
      OPC_SLTI: begin
        op    = SLT;
        b_sel = B_IMM;
      end
      OPC_BEQ: begin
        op    = SUB;
        b_sel = B_RT;
      end
      OPC_J:   op = HOLD;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_issue.sv
// ID->EX issue stage with 2-entry skid buffer; optional operand forwarding under ALU_FWD_EN.
// 1-cycle latency, full throughput; registered in_ready drops only when both entries are held.
module alu_op_issue
  import mips_pkg::*;
#(
  parameter int DW = XLEN,
  parameter int RW = RIDX
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [5:0]    opcode,
  input  logic [5:0]    funct,
  input  logic [DW-1:0] rs_data,
  input  logic [DW-1:0] rt_data,
  input  logic [DW-1:0] imm_sext,
`ifdef ALU_FWD_EN
  input  logic          exmem_wr,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_res,
  input  logic          memwb_wr,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_res,
  input  logic [RW-1:0] rs_idx,
  input  logic [RW-1:0] rt_idx,
`endif
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_op,
  output logic          illegal
);

  buf_state_t   state_q, state_d;
  issue_entry_t main_q, main_d;
  issue_entry_t skid_q, skid_d;
  issue_entry_t in_entry;

  alu_op_t dec_op;
  b_sel_t  dec_b_sel;
  logic    dec_illegal;
  logic    accept;
  logic    pop;

  alu_op_decode u_decode (
    .opcode  (opcode),
    .funct   (funct),
    .op      (dec_op),
    .b_sel   (dec_b_sel),
    .illegal (dec_illegal)
  );

  always_comb begin
    in_entry         = '0;
    in_entry.a       = rs_data;
    in_entry.op      = dec_op;
    in_entry.illegal = dec_illegal;
    in_entry.b_is_rt = (dec_b_sel == B_RT);
    case (dec_b_sel)
      B_RT:    in_entry.b = rt_data;
      B_IMM:   in_entry.b = imm_sext;
      default: in_entry.b = '0;
    endcase
`ifdef ALU_FWD_EN
    in_entry.rs_idx = rs_idx;
    in_entry.rt_idx = rt_idx;
`endif
  end

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Flush wins over any same-cycle accept; a same-cycle pop has already handshaken.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin
          main_d  = in_entry;
          state_d = ONE;
        end
        ONE: begin
          if (accept && pop) begin
            main_d = in_entry;
          end else if (accept) begin
            skid_d  = in_entry;
            state_d = TWO;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: if (pop) begin
          main_d  = skid_q;
          state_d = ONE;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign alu_op  = out_valid ? main_q.op : HOLD;
  assign illegal = out_valid & main_q.illegal;

`ifdef ALU_FWD_EN
  // EX/MEM is applied last so it overrides MEM/WB for the same register.
  always_comb begin
    alu_a = main_q.a;
    alu_b = main_q.b;
    if (memwb_wr && memwb_rd != '0 && memwb_rd == main_q.rs_idx) alu_a = memwb_res;
    if (exmem_wr && exmem_rd != '0 && exmem_rd == main_q.rs_idx) alu_a = exmem_res;
    if (main_q.b_is_rt) begin
      if (memwb_wr && memwb_rd != '0 && memwb_rd == main_q.rt_idx) alu_b = memwb_res;
      if (exmem_wr && exmem_rd != '0 && exmem_rd == main_q.rt_idx) alu_b = exmem_res;
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{main_q.b_is_rt, main_q.rs_idx, main_q.rt_idx};
  assign alu_a = main_q.a;
  assign alu_b = main_q.b;
`endif

endmodule

// File: tb/tb_alu_op_issue.sv
// Scoreboarded bench for alu_op_issue: directed vectors with hand-computed expectations.
module tb_alu_op_issue;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  opcode = '0;
  logic [5:0]  funct = '0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic [31:0] imm_sext = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic        illegal;
`ifdef ALU_FWD_EN
  logic        exmem_wr = 1'b0;
  logic [4:0]  exmem_rd = '0;
  logic [31:0] exmem_res = '0;
  logic        memwb_wr = 1'b0;
  logic [4:0]  memwb_rd = '0;
  logic [31:0] memwb_res = '0;
  logic [4:0]  rs_idx = '0;
  logic [4:0]  rt_idx = '0;
`endif

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  alu_op_issue dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .funct     (funct),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .imm_sext  (imm_sext),
`ifdef ALU_FWD_EN
    .exmem_wr  (exmem_wr),
    .exmem_rd  (exmem_rd),
    .exmem_res (exmem_res),
    .memwb_wr  (memwb_wr),
    .memwb_rd  (memwb_rd),
    .memwb_res (memwb_res),
    .rs_idx    (rs_idx),
    .rt_idx    (rt_idx),
`endif
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endfunction

  // Monitor: every output handshake pops one expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL sb_unexpected: got a=%0h b=%0h op=%0h ill=%0b, expected no output",
                   alu_a, alu_b, alu_op, illegal);
        end else begin
          e = exp_q.pop_front();
          chk("sb_out", {alu_a, alu_b, alu_op, illegal}, {e.a, e.b, e.op, e.ill});
        end
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send(input logic [5:0] opc, input logic [5:0] fn, input logic [31:0] rs,
                      input logic [31:0] rt, input logic [31:0] imm,
                      input logic [31:0] ea, input logic [31:0] eb,
                      input logic [2:0] eop, input logic eill);
    int t = 0;
    exp_t e;
    opcode = opc; funct = fn; rs_data = rs; rt_data = rt; imm_sext = imm;
    in_valid = 1'b1;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: got in_ready=0 for 50 cycles, expected 1");
      in_valid = 1'b0;
    end else begin
      e.a = ea; e.b = eb; e.op = eop; e.ill = eill;
      exp_q.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int t;
    // Reset state
    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_alu_ab", {alu_a, alu_b}, 64'h0);
    chk("rst_alu_op", alu_op, 3'b111);
    chk("rst_illegal", illegal, 1'b0);
    cycles(2);
    rst_n = 1'b1;
    cycles(1);

    // 1: single add, 1-cycle latency, hold after drain
    out_ready = 1'b1;
    send(6'h00, 6'h20, 32'd5, 32'd7, 32'd0, 32'd5, 32'd7, 3'b000, 1'b0);
    chk("t1_latency_valid", out_valid, 1'b1);
    chk("t1_op", alu_op, 3'b000);
    cycles(1);
    chk("t1_drain_valid", out_valid, 1'b0);
    chk("t1_drain_hold_op", alu_op, 3'b111);
    chk("t1_drain_keep_a", alu_a, 32'd5);

    // 2: stall fills skid; release drains in order
    out_ready = 1'b0;
    send(6'h08, 6'h00, 32'd10, 32'd123, 32'hFFFF_FFFC, 32'd10, 32'hFFFF_FFFC, 3'b000, 1'b0);
    send(6'h00, 6'h22, 32'd20, 32'd6, 32'd0, 32'd20, 32'd6, 3'b001, 1'b0);
    chk("t2_in_ready_full", in_ready, 1'b0);
    cycles(2);
    chk("t2_stall_stable", {alu_b, alu_op}, {32'hFFFF_FFFC, 3'b000});
    out_ready = 1'b1;
    cycles(3);
    chk("t2_drained", out_valid, 1'b0);

    // 3: flush with skid full and a same-cycle input
    out_ready = 1'b0;
    send(6'h00, 6'h24, 32'd3, 32'd5, 32'd0, 32'd3, 32'd5, 3'b010, 1'b0);
    send(6'h00, 6'h25, 32'd4, 32'd8, 32'd0, 32'd4, 32'd8, 3'b011, 1'b0);
    opcode = 6'h00; funct = 6'h20; rs_data = 32'd1; rt_data = 32'd1;
    in_valid = 1'b1;
    flush = 1'b1;
    cycles(1);
    flush = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    chk("t3_flush_state", {out_valid, in_ready, alu_op}, {1'b0, 1'b1, 3'b111});
    out_ready = 1'b1;
    cycles(2);
    chk("t3_no_survivor", out_valid, 1'b0);

    // 4: decode table, back-to-back
    send(6'h3F, 6'h00, 32'd9, 32'd4, 32'd6, 32'd9, 32'd0, 3'b111, 1'b1);
    send(6'h0A, 6'h00, 32'd11, 32'd4, 32'd3, 32'd11, 32'd3, 3'b100, 1'b0);
    send(6'h04, 6'h00, 32'd1, 32'd2, 32'd9, 32'd1, 32'd2, 3'b001, 1'b0);
    send(6'h23, 6'h00, 32'h100, 32'd2, 32'd16, 32'h100, 32'd16, 3'b000, 1'b0);
    send(6'h2B, 6'h00, 32'h200, 32'd2, 32'd8, 32'h200, 32'd8, 3'b000, 1'b0);
    send(6'h02, 6'h00, 32'd7, 32'd2, 32'd8, 32'd7, 32'd0, 3'b111, 1'b0);
    send(6'h00, 6'h2A, 32'd3, 32'd9, 32'd1, 32'd3, 32'd9, 3'b100, 1'b0);
    send(6'h00, 6'h21, 32'd3, 32'd9, 32'd1, 32'd3, 32'd0, 3'b111, 1'b1);
    cycles(2);

    // 5: async reset while both entries held
    out_ready = 1'b0;
    send(6'h00, 6'h20, 32'd1, 32'd2, 32'd0, 32'd1, 32'd2, 3'b000, 1'b0);
    send(6'h00, 6'h22, 32'd3, 32'd4, 32'd0, 32'd3, 32'd4, 3'b001, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_clear", {out_valid, in_ready, alu_op, illegal}, {1'b0, 1'b1, 3'b111, 1'b0});
    exp_q.delete();
    cycles(1);
    rst_n = 1'b1;
    out_ready = 1'b1;
    cycles(3);
    chk("t5_no_stale", out_valid, 1'b0);

`ifdef ALU_FWD_EN
    // 6: forwarding priority, $0 exclusion, immediate B untouched
    exmem_wr = 1'b1; exmem_rd = 5'd8; exmem_res = 32'd99;
    memwb_wr = 1'b1; memwb_rd = 5'd8; memwb_res = 32'd55;
    rs_idx = 5'd8; rt_idx = 5'd8;
    send(6'h00, 6'h20, 32'd1234, 32'd2, 32'd0, 32'd99, 32'd99, 3'b000, 1'b0);
    rs_idx = 5'd8; rt_idx = 5'd8;
    send(6'h08, 6'h00, 32'd1234, 32'd2, 32'd5, 32'd99, 32'd5, 3'b000, 1'b0);
    cycles(2);
    exmem_rd = 5'd0; memwb_rd = 5'd0;
    rs_idx = 5'd0; rt_idx = 5'd0;
    send(6'h00, 6'h20, 32'd1234, 32'd2, 32'd0, 32'd1234, 32'd2, 3'b000, 1'b0);
    memwb_rd = 5'd9; rt_idx = 5'd9; memwb_res = 32'd77;
    send(6'h00, 6'h22, 32'd10, 32'd2, 32'd0, 32'd10, 32'd77, 3'b001, 1'b0);
    cycles(2);
    exmem_wr = 1'b0; memwb_wr = 1'b0;
`endif

    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d entries outstanding, expected 0", exp_q.size());
    end
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
